main_mem_responder: RTL

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder_pkg.sv | 5 +
 rtl/main_mem_responder_if.sv | 17 +
 rtl/main_mem_responder_mem_array.sv | 20 ++
 rtl/main_mem_responder.sv | 77 +++++++
 4 files changed

// File: rtl/main_mem_responder_pkg.sv
// main_mem_responder_pkg: package mem_pkg with the responder FSM state type and default latency
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int DEFAULT_LATENCY = 4;
endpackage

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: request/response bus between the cache refill side (master) and the responder (slave)
interface main_mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  iReq;
    logic                  iWrite;
    logic [31:0]           iAddress;
    logic [DATA_WIDTH-1:0] iWriteData;
    logic                  oReady;
    logic                  oValid;
    logic [DATA_WIDTH-1:0] oData;
    logic                  oError;
    modport master (output iReq, iWrite, iAddress, iWriteData, input oReady, oValid, oData, oError);
    modport slave (input iReq, iWrite, iAddress, iWriteData, output oReady, oValid, oData, oError);
endinterface

// File: rtl/main_mem_responder_mem_array.sv
// mem_array: single-port storage, synchronous write, combinational read, contents never reset
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    // write the addressed word when enabled
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency memory responder; define MEM_ERR_EN to flag misaligned/out-of-range addresses
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input logic                  iCLK,
    input logic                  iRSTn,
    main_mem_responder_if.slave  bus
);
    state_t                state;
    logic [3:0]            cnt;
    logic                  write_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err_in;
    logic                  we;
`ifdef MEM_ERR_EN
    assign err_in = (bus.iAddress[1:0] != 2'd0) || ((bus.iAddress >> (ADDR_WIDTH + 2)) != 32'd0);
`else
    logic unused_addr;
    assign err_in      = 1'b0;
    assign unused_addr = ^bus.iAddress;
`endif
    // commit happens on the edge leaving RESP; a reset on that edge cancels it
    assign we = (state == RESP) && write_q && !err_q && iRSTn;
    mem_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk   (iCLK),
        .we    (we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );
    // request FSM: accept in IDLE, count down in WAIT, pulse the response in RESP
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            bus.oReady <= 1'b1;
            bus.oValid <= 1'b0;
            bus.oData  <= '0;
            bus.oError <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.iReq) begin
                    write_q    <= bus.iWrite;
                    idx_q      <= bus.iAddress[ADDR_WIDTH+1:2];
                    wdata_q    <= bus.iWriteData;
                    err_q      <= err_in;
                    cnt        <= 4'(LATENCY - 1);
                    bus.oReady <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: if (cnt == 4'd0) begin
                    bus.oValid <= 1'b1;
                    bus.oData  <= (write_q || err_q) ? '0 : rdata;
                    bus.oError <= err_q;
                    state      <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    bus.oValid <= 1'b0;
                    bus.oData  <= '0;
                    bus.oError <= 1'b0;
                    bus.oReady <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
